chroma_subsample: RTL and testbench
===================================

CHROMA_SUBSAMPLE -- requirements
Module: chroma_subsample

Interface
REQ-001 SHALL have parameter SENSOR_X_SIZE, default 720, maximum pixels per line (even).
REQ-002 SHALL have parameter SENSOR_Y_SIZE, default 720, maximum lines per frame.
REQ-003 SHALL have parameter DW, default 8, bits per component.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have port yuvrgb_in[2:0], input, DW each: Y, Cb, Cr.
REQ-007 SHALL have ports yuvrgb_in_valid (input, 1 bit) and yuvrgb_in_hold (output, 1 bit): input handshake.
REQ-008 SHALL have ports frame_valid_in and line_valid_in, input, 1 bit each: sensor framing.
REQ-009 SHALL have port mode_in, input, 2 bits: 0 = 4:4:4, 1 = 4:2:2, 2 = 4:2:0, 3 = 4:0:0.
REQ-010 SHALL have ports yuvrgb_out[2:0] (output, DW each) and yuvrgb_out_valid (output, 3 bits, one per component).
REQ-011 SHALL have ports yuvrgb_out_hold (input, 1 bit) and eof_out (output, 1 bit).
REQ-012 SHALL have ports yuvrgb_out_pixel_count (output, clog2(SENSOR_X_SIZE) bits) and yuvrgb_out_line_count (output, clog2(SENSOR_Y_SIZE) bits).
REQ-013 SHALL have port odd_line_err, output, 1 bit: sticky flag for an odd-length line in modes 1 and 2.

Function
REQ-014 SHALL drive yuvrgb_in_hold combinationally equal to yuvrgb_out_hold.
REQ-015 A beat SHALL be accepted when line_valid_in & yuvrgb_in_valid & !yuvrgb_in_hold; all state SHALL freeze while hold=1.
REQ-016 SHALL latch mode_in into active_mode on the rising edge of frame_valid_in only; mid-frame changes SHALL be ignored.
REQ-017 eol (line_valid_in falling) SHALL clear pixel_count and increment line_count; eof (frame_valid_in falling) SHALL clear both and take priority over eol.
REQ-018 Outputs SHALL be registered with 1-cycle latency from the accepted beat; Y valid SHALL assert for every accepted beat in all modes.
REQ-019 Mode 0 SHALL pass Cb and Cr through with their valid bits asserted on every Y beat.
REQ-020 Mode 3 SHALL keep Cb/Cr valid bits at 0.
REQ-021 Mode 1 SHALL, on each odd pixel, output Cb = (Cb_even + Cb_odd + 1) >> 1, and likewise for Cr, with both chroma valid bits set on that beat only.
REQ-022 Mode 2 SHALL, on even lines, write the (DW+1)-bit pair sums of Cb and Cr into a line buffer (depth SENSOR_X_SIZE/2, width 2*(DW+1)) at address pixel_count>>1.
REQ-023 Mode 2 SHALL, on odd lines and odd pixels, output (buffered_sum + current_pair_sum + 2) >> 2 per chroma, with both chroma valid bits set; even lines SHALL emit no chroma.
REQ-024 Intermediate sums SHALL be DW+2 bits wide; there SHALL be no overflow or saturation.
REQ-025 In modes 1 and 2, a line ending on an even pixel_count index (odd length) SHALL drop the unpaired chroma and set odd_line_err until reset.
REQ-026 eof_out SHALL pulse for 1 cycle, one cycle after eof.
REQ-027 The pixel and line count outputs SHALL register the counts of the beat producing the current output.
REQ-028 pixel_count reaching SENSOR_X_SIZE SHALL hold at SENSOR_X_SIZE-1 and set odd_line_err.

Reset
REQ-029 On reset the block SHALL set yuvrgb_out_valid=0, eof_out=0, odd_line_err=0, pixel_count=0, line_count=0, active_mode=2 and the output count registers to 0.
REQ-030 Line buffer contents SHALL NOT be cleared; they SHALL NOT be read before being written in the current frame.
REQ-031 Reset mid-frame SHALL abort the frame; processing SHALL resume at the next frame_valid_in rising edge.

Verification
REQ-032 Mode 1 with line Cb = 10, 13 -> one chroma output Cb = 12 with valid=3'b111 on the second beat only.
REQ-033 Mode 2 with 2x2 Cb = 10, 20 / 30, 41 -> Cb = 25 on line 1, pixel 1; no chroma valid on line 0.
REQ-034 Mode 2 with all chroma 255 (DW=8) -> output 255, with no wrap.
REQ-035 Hold asserted 3 cycles mid-line -> outputs, counters and valids frozen; no beats lost or duplicated.
REQ-036 mode_in changed 0 to 3 mid-frame -> the frame stays 4:4:4 and the next frame has no chroma valids.
REQ-037 Mode 1 with a 5-pixel line -> 2 chroma outputs and odd_line_err=1; reset clears the flag.

Source files
------------

// File: rtl/chroma_subsample.sv
// Chroma subsampler: turns a YCbCr 4:4:4 pixel stream into 4:4:4, 4:2:2, 4:2:0 or 4:0:0.
// Outputs are registered one cycle after each accepted beat, and the whole pipeline stalls while yuvrgb_out_hold is high.
module chroma_subsample #(
   parameter int SENSOR_X_SIZE = 720,
   parameter int SENSOR_Y_SIZE = 720,
   parameter int DW            = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0][DW-1:0]               yuvrgb_in,
   input  logic                             yuvrgb_in_valid,
   output logic                             yuvrgb_in_hold,
   input  logic                             frame_valid_in,
   input  logic                             line_valid_in,
   input  logic [1:0]                       mode_in,
   output logic [2:0][DW-1:0]               yuvrgb_out,
   output logic [2:0]                       yuvrgb_out_valid,
   input  logic                             yuvrgb_out_hold,
   output logic                             eof_out,
   output logic [$clog2(SENSOR_X_SIZE)-1:0] yuvrgb_out_pixel_count,
   output logic [$clog2(SENSOR_Y_SIZE)-1:0] yuvrgb_out_line_count,
   output logic                             odd_line_err
);
   localparam int PXW       = $clog2(SENSOR_X_SIZE);
   localparam int LNW       = $clog2(SENSOR_Y_SIZE);
   localparam int BUF_DEPTH = SENSOR_X_SIZE / 2;
   localparam int ADW       = $clog2(BUF_DEPTH);
   localparam logic [PXW-1:0]  PX_LAST_C = PXW'(SENSOR_X_SIZE - 1);
   localparam logic [PXW-1:0]  PX_ONE_C  = PXW'(1);
   localparam logic [LNW-1:0]  LN_ONE_C  = LNW'(1);
   localparam logic [DW+1:0]   ONE_C     = {{(DW+1){1'b0}}, 1'b1};
   localparam logic [DW+1:0]   TWO_C     = {{DW{1'b0}}, 2'b10};

   typedef enum logic [1:0] {
      MODE_444 = 2'd0,
      MODE_422 = 2'd1,
      MODE_420 = 2'd2,
      MODE_400 = 2'd3
   } mode_t;

   mode_t            active_mode_r;
   logic             fv_prev_r;
   logic             lv_prev_r;
   logic             in_frame_r;
   logic [PXW-1:0]   pixel_count_r;
   logic [LNW-1:0]   line_count_r;
   logic [DW-1:0]    cb_even_r;
   logic [DW-1:0]    cr_even_r;
   logic [2*DW+1:0]  line_buf_r [0:BUF_DEPTH-1];

   logic             frame_rise_s;
   logic             frame_fall_s;
   logic             line_fall_s;
   logic             beat_s;
   logic             pair_mode_s;
   logic [ADW-1:0]   buf_addr_s;
   logic [2*DW+1:0]  buf_word_s;
   logic [DW:0]      cb_pair_s;
   logic [DW:0]      cr_pair_s;
   logic [DW-1:0]    cb_q2_s;
   logic [DW-1:0]    cr_q2_s;
   logic [DW-1:0]    cb_q4_s;
   logic [DW-1:0]    cr_q4_s;

   assign yuvrgb_in_hold = yuvrgb_out_hold;

   // Framing edges, beat acceptance and chroma averaging arithmetic
   always_comb begin
      frame_rise_s = frame_valid_in & ~fv_prev_r;
      frame_fall_s = ~frame_valid_in & fv_prev_r & in_frame_r;
      line_fall_s  = ~line_valid_in & lv_prev_r & in_frame_r;
      beat_s       = line_valid_in & yuvrgb_in_valid & ~yuvrgb_out_hold & frame_valid_in & in_frame_r;
      pair_mode_s  = (active_mode_r == MODE_422) || (active_mode_r == MODE_420);
      buf_addr_s   = pixel_count_r[PXW-1:1];
      buf_word_s   = line_buf_r[buf_addr_s];
      cb_pair_s    = {1'b0, cb_even_r} + {1'b0, yuvrgb_in[1]};
      cr_pair_s    = {1'b0, cr_even_r} + {1'b0, yuvrgb_in[2]};
      // Sums are kept at DW+2 bits so a full-scale quad cannot wrap before rounding
      cb_q2_s      = DW'(({1'b0, cb_pair_s} + ONE_C) >> 1);
      cr_q2_s      = DW'(({1'b0, cr_pair_s} + ONE_C) >> 1);
      cb_q4_s      = DW'(({1'b0, buf_word_s[DW:0]} + {1'b0, cb_pair_s} + TWO_C) >> 2);
      cr_q4_s      = DW'(({1'b0, buf_word_s[2*DW+1:DW+1]} + {1'b0, cr_pair_s} + TWO_C) >> 2);
   end

   // Framing state, counters, mode latch and the registered output stage
   always_ff @(posedge clk) begin
      if (reset) begin
         // fv_prev starts high so a frame already in progress is not mistaken for a new one
         fv_prev_r              <= 1'b1;
         lv_prev_r              <= 1'b0;
         in_frame_r             <= 1'b0;
         active_mode_r          <= MODE_420;
         pixel_count_r          <= {PXW{1'b0}};
         line_count_r           <= {LNW{1'b0}};
         cb_even_r              <= {DW{1'b0}};
         cr_even_r              <= {DW{1'b0}};
         yuvrgb_out             <= {(3*DW){1'b0}};
         yuvrgb_out_valid       <= 3'b000;
         eof_out                <= 1'b0;
         odd_line_err           <= 1'b0;
         yuvrgb_out_pixel_count <= {PXW{1'b0}};
         yuvrgb_out_line_count  <= {LNW{1'b0}};
      end else if (!yuvrgb_out_hold) begin
         fv_prev_r        <= frame_valid_in;
         lv_prev_r        <= line_valid_in;
         eof_out          <= frame_fall_s;
         yuvrgb_out_valid <= 3'b000;
         if (frame_rise_s) begin
            in_frame_r    <= 1'b1;
            active_mode_r <= mode_t'(mode_in);
         end else if (frame_fall_s) begin
            in_frame_r    <= 1'b0;
         end
         if (line_fall_s && pair_mode_s && pixel_count_r[0]) begin
            odd_line_err <= 1'b1;
         end
         if (frame_fall_s || frame_rise_s) begin
            pixel_count_r <= {PXW{1'b0}};
            line_count_r  <= {LNW{1'b0}};
         end else if (line_fall_s) begin
            pixel_count_r <= {PXW{1'b0}};
            line_count_r  <= line_count_r + LN_ONE_C;
         end else if (beat_s) begin
            if (pixel_count_r == PX_LAST_C) begin
               odd_line_err <= 1'b1;
            end else begin
               pixel_count_r <= pixel_count_r + PX_ONE_C;
            end
         end
         if (beat_s) begin
            yuvrgb_out_pixel_count <= pixel_count_r;
            yuvrgb_out_line_count  <= line_count_r;
            yuvrgb_out[0]          <= yuvrgb_in[0];
            if (!pixel_count_r[0]) begin
               cb_even_r <= yuvrgb_in[1];
               cr_even_r <= yuvrgb_in[2];
            end
            case (active_mode_r)
               MODE_444: begin
                  yuvrgb_out[1]    <= yuvrgb_in[1];
                  yuvrgb_out[2]    <= yuvrgb_in[2];
                  yuvrgb_out_valid <= 3'b111;
               end
               MODE_422: begin
                  yuvrgb_out[1]    <= cb_q2_s;
                  yuvrgb_out[2]    <= cr_q2_s;
                  yuvrgb_out_valid <= pixel_count_r[0] ? 3'b111 : 3'b001;
               end
               MODE_420: begin
                  yuvrgb_out[1]    <= cb_q4_s;
                  yuvrgb_out[2]    <= cr_q4_s;
                  yuvrgb_out_valid <= (pixel_count_r[0] && line_count_r[0]) ? 3'b111 : 3'b001;
               end
               MODE_400: begin
                  yuvrgb_out[1]    <= yuvrgb_in[1];
                  yuvrgb_out[2]    <= yuvrgb_in[2];
                  yuvrgb_out_valid <= 3'b001;
               end
               default: begin
                  yuvrgb_out_valid <= 3'b001;
               end
            endcase
         end
      end
   end

   // 4:2:0 line buffer: even lines store pair sums, odd lines read them back; never cleared
   always_ff @(posedge clk) begin
      if (!reset && beat_s && (active_mode_r == MODE_420) && !line_count_r[0] && pixel_count_r[0]) begin
         line_buf_r[buf_addr_s] <= {cr_pair_s, cb_pair_s};
      end
   end
endmodule

// File: tb/tb_chroma_subsample.sv
// Self-checking bench for chroma_subsample: a table of small frames, directed corner cases and random frames,
// all checked cycle by cycle against a frame-level arithmetic model.
module tb_chroma_subsample;
   localparam int XS = 16;
   localparam int YS = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [2:0][7:0] yuvrgb_in;
   logic            yuvrgb_in_valid;
   logic            yuvrgb_in_hold;
   logic            frame_valid_in;
   logic            line_valid_in;
   logic [1:0]      mode_in;
   logic [2:0][7:0] yuvrgb_out;
   logic [2:0]      yuvrgb_out_valid;
   logic            yuvrgb_out_hold;
   logic            eof_out;
   logic [3:0]      pix_cnt;
   logic [2:0]      lin_cnt;
   logic            odd_line_err;

   chroma_subsample #(.SENSOR_X_SIZE(XS), .SENSOR_Y_SIZE(YS), .DW(8)) dut (
      .clk(clk), .reset(reset), .yuvrgb_in(yuvrgb_in), .yuvrgb_in_valid(yuvrgb_in_valid),
      .yuvrgb_in_hold(yuvrgb_in_hold), .frame_valid_in(frame_valid_in), .line_valid_in(line_valid_in),
      .mode_in(mode_in), .yuvrgb_out(yuvrgb_out), .yuvrgb_out_valid(yuvrgb_out_valid),
      .yuvrgb_out_hold(yuvrgb_out_hold), .eof_out(eof_out), .yuvrgb_out_pixel_count(pix_cnt),
      .yuvrgb_out_line_count(lin_cnt), .odd_line_err(odd_line_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // frame under test
   logic [7:0] f_y [0:7][0:19];
   logic [7:0] f_cb[0:7][0:19];
   logic [7:0] f_cr[0:7][0:19];
   int         f_len[0:7];
   int         f_lines;
   int         f_mode;

   // expected output state
   logic [2:0] e_valid;
   logic [7:0] e_y, e_cb, e_cr;
   int         e_px, e_ln;
   logic       e_eof, e_err;
   logic       hold_drv;
   int         n_ch;
   logic [7:0] last_cb, last_cr;

   typedef struct packed {
      logic [1:0]      mode;
      logic [1:0]      nlines;
      logic [3:0][7:0] cb;
      logic [3:0][7:0] cr;
      logic [1:0]      nch;
      logic [7:0]      ecb;
      logic [7:0]      ecr;
   } vec_t;
   vec_t tbl[0:7];

   function automatic vec_t mk(input int m, nl, c0, c1, c2, c3, r0, r1, r2, r3, nch, ecb, ecr);
      vec_t v;
      v.mode = 2'(m); v.nlines = 2'(nl); v.nch = 2'(nch); v.ecb = 8'(ecb); v.ecr = 8'(ecr);
      v.cb[0] = 8'(c0); v.cb[1] = 8'(c1); v.cb[2] = 8'(c2); v.cb[3] = 8'(c3);
      v.cr[0] = 8'(r0); v.cr[1] = 8'(r1); v.cr[2] = 8'(r2); v.cr[3] = 8'(r3);
      return v;
   endfunction

   task automatic drive(input logic rst, fv, lv, vld, hld, input logic [1:0] md,
                        input logic [7:0] y, cb, cr);
      reset = rst; frame_valid_in = fv; line_valid_in = lv; yuvrgb_in_valid = vld;
      yuvrgb_out_hold = hld; hold_drv = hld; mode_in = md;
      yuvrgb_in[0] = y; yuvrgb_in[1] = cb; yuvrgb_in[2] = cr;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name);
      logic ok;
      n_vec++;
      ok = (yuvrgb_out_valid === e_valid) && (eof_out === e_eof) && (odd_line_err === e_err) &&
           (int'(pix_cnt) == e_px) && (int'(lin_cnt) == e_ln) && (yuvrgb_in_hold === hold_drv);
      if (e_valid[0] && yuvrgb_out[0] !== e_y)  ok = 1'b0;
      if (e_valid[1] && yuvrgb_out[1] !== e_cb) ok = 1'b0;
      if (e_valid[2] && yuvrgb_out[2] !== e_cr) ok = 1'b0;
      if (!ok) begin
         n_err++;
         $display("FAIL %s @%0t: got v=%b y=%0d cb=%0d cr=%0d px=%0d ln=%0d eof=%b err=%b ihold=%b; want v=%b y=%0d cb=%0d cr=%0d px=%0d ln=%0d eof=%b err=%b ihold=%b",
                  name, $time, yuvrgb_out_valid, yuvrgb_out[0], yuvrgb_out[1], yuvrgb_out[2], pix_cnt, lin_cnt,
                  eof_out, odd_line_err, yuvrgb_in_hold, e_valid, e_y, e_cb, e_cr, e_px, e_ln, e_eof, e_err, hold_drv);
      end
   endtask

   // Frame-level model: the expected output for pixel p of line l in the current frame
   task automatic model_beat(input int l, input int p);
      e_valid = 3'b001;
      e_y     = f_y[l][p];
      e_px    = (p > XS - 1) ? XS - 1 : p;
      e_ln    = l;
      if (p >= XS - 1) e_err = 1'b1;
      if (f_mode == 0) begin
         e_valid = 3'b111; e_cb = f_cb[l][p]; e_cr = f_cr[l][p];
      end else if (f_mode == 1 && p % 2 == 1) begin
         e_valid = 3'b111;
         e_cb = 8'((int'(f_cb[l][p-1]) + int'(f_cb[l][p]) + 1) / 2);
         e_cr = 8'((int'(f_cr[l][p-1]) + int'(f_cr[l][p]) + 1) / 2);
      end else if (f_mode == 2 && l % 2 == 1 && p % 2 == 1) begin
         e_valid = 3'b111;
         e_cb = 8'((int'(f_cb[l-1][p-1]) + int'(f_cb[l-1][p]) + int'(f_cb[l][p-1]) + int'(f_cb[l][p]) + 2) / 4);
         e_cr = 8'((int'(f_cr[l-1][p-1]) + int'(f_cr[l-1][p]) + int'(f_cr[l][p-1]) + int'(f_cr[l][p]) + 2) / 4);
      end
   endtask

   task automatic do_reset(input logic fv);
      drive(1'b1, fv, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      e_valid = 3'b000; e_eof = 1'b0; e_err = 1'b0; e_px = 0; e_ln = 0;
      check("reset_state");
   endtask

   task automatic play_frame(input bit gaps, input bit wiggle, input bit hold3);
      int p;
      bit v, h, did3;
      logic [1:0] md;
      n_ch = 0; did3 = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(f_mode), 8'd0, 8'd0, 8'd0);
      e_valid = 3'b000; e_eof = 1'b0;
      check("frame_start");
      for (int l = 0; l < f_lines; l++) begin
         p = 0;
         while (p < f_len[l]) begin
            if (hold3 && !did3 && l == 0 && p == 2) begin
               for (int k = 0; k < 3; k++) begin
                  drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'(f_mode), f_y[l][p], f_cb[l][p], f_cr[l][p]);
                  check("hold_frozen");
               end
               did3 = 1'b1;
            end
            v  = !gaps || ($urandom_range(0, 3) != 0);
            h  = gaps && ($urandom_range(0, 7) == 0);
            md = wiggle ? 2'($urandom) : 2'(f_mode);
            drive(1'b0, 1'b1, 1'b1, v, h, md, f_y[l][p], f_cb[l][p], f_cr[l][p]);
            if (!h) begin
               e_eof = 1'b0;
               if (v) begin
                  model_beat(l, p);
                  p++;
               end else begin
                  e_valid = 3'b000;
               end
            end
            check("beat");
            if (!h && v && yuvrgb_out_valid[1]) begin
               n_ch++; last_cb = yuvrgb_out[1]; last_cr = yuvrgb_out[2];
            end
         end
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'(f_mode), 8'd0, 8'd0, 8'd0);
         e_valid = 3'b000;
         if ((f_mode == 1 || f_mode == 2) && f_len[l] % 2 == 1) e_err = 1'b1;
         check("eol");
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(f_mode), 8'd0, 8'd0, 8'd0);
      e_eof = 1'b1;
      check("eof_pulse");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'(f_mode), 8'd0, 8'd0, 8'd0);
      e_eof = 1'b0;
      check("idle");
   endtask

   task automatic rand_fill(input int mode, input int lines, input int len);
      f_mode = mode; f_lines = lines;
      for (int l = 0; l < lines; l++) begin
         f_len[l] = len;
         for (int p = 0; p < 20; p++) begin
            f_y[l][p] = 8'($urandom); f_cb[l][p] = 8'($urandom); f_cr[l][p] = 8'($urandom);
         end
      end
   endtask

   initial begin
      int len;
      tbl[0] = mk(1, 1,  10,  13,   0,   0,    0,   1,   0,   0,  1,  12,   1);
      tbl[1] = mk(2, 2,  10,  20,  30,  41,    0,   0,   0,   1,  1,  25,   0);
      tbl[2] = mk(2, 2, 255, 255, 255, 255,  255, 255, 255, 255,  1, 255, 255);
      tbl[3] = mk(0, 1,   7,   9,   0,   0,    1,   2,   0,   0,  2,   9,   2);
      tbl[4] = mk(3, 2,  50,  60,  70,  80,   90, 100, 110, 120,  0,   0,   0);
      tbl[5] = mk(1, 1, 255, 254,   0,   0,    0, 255,   0,   0,  1, 255, 128);
      tbl[6] = mk(2, 2,   1,   2,   3,   4,  200, 100,  50,  51,  1,   3, 100);
      tbl[7] = mk(1, 2,   1,   2,   3,   4,    0,   0,   9,   8,  2,   4,   9);

      e_y = 8'd0; e_cb = 8'd0; e_cr = 8'd0; last_cb = 8'd0; last_cr = 8'd0;
      do_reset(1'b0);
      do_reset(1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      check("post_reset_idle");

      for (int i = 0; i < 8; i++) begin
         rand_fill(int'(tbl[i].mode), int'(tbl[i].nlines), 2);
         for (int k = 0; k < 4; k++) begin
            f_cb[k / 2][k % 2] = tbl[i].cb[k];
            f_cr[k / 2][k % 2] = tbl[i].cr[k];
         end
         play_frame(1'b0, 1'b0, 1'b0);
         n_vec++;
         if (n_ch != int'(tbl[i].nch) || (tbl[i].nch != 2'd0 && (last_cb != tbl[i].ecb || last_cr != tbl[i].ecr))) begin
            n_err++;
            $display("FAIL table[%0d]: got chroma_outs=%0d cb=%0d cr=%0d, want chroma_outs=%0d cb=%0d cr=%0d",
                     i, n_ch, last_cb, last_cr, tbl[i].nch, tbl[i].ecb, tbl[i].ecr);
         end
      end

      // three-cycle hold in the middle of a 4:2:2 line
      rand_fill(1, 1, 8);
      play_frame(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (n_ch != 4) begin
         n_err++; $display("FAIL hold3_count: got %0d chroma outputs, want 4", n_ch);
      end

      // mode_in wiggles mid-frame: the frame stays 4:4:4, the next frame latches 4:0:0
      rand_fill(0, 2, 6);
      play_frame(1'b0, 1'b1, 1'b0);
      n_vec++;
      if (n_ch != 12) begin
         n_err++; $display("FAIL mode_latch_444: got %0d chroma outputs, want 12", n_ch);
      end
      rand_fill(3, 2, 6);
      play_frame(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (n_ch != 0) begin
         n_err++; $display("FAIL mode_400_chroma: got %0d chroma outputs, want 0", n_ch);
      end

      // odd-length 4:2:2 line
      rand_fill(1, 1, 5);
      play_frame(1'b0, 1'b0, 1'b0);
      n_vec++;
      if (n_ch != 2 || odd_line_err !== 1'b1) begin
         n_err++; $display("FAIL odd_line: got chroma_outs=%0d err=%b, want chroma_outs=2 err=1", n_ch, odd_line_err);
      end
      do_reset(1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      check("idle_after_reset");

      // reset in the middle of a frame aborts it until the next frame_valid rising edge
      rand_fill(0, 1, 4);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      e_valid = 3'b000;
      check("abort_start");
      for (int p = 0; p < 2; p++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, f_y[0][p], f_cb[0][p], f_cr[0][p]);
         model_beat(0, p);
         check("abort_beat");
      end
      do_reset(1'b1);
      for (int p = 2; p < 4; p++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, f_y[0][p], f_cb[0][p], f_cr[0][p]);
         check("ignored_after_reset");
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      check("ignored_eol");
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      check("no_eof_after_abort");
      play_frame(1'b0, 1'b0, 1'b0);

      // pixel counter saturation on an overlong line
      rand_fill(0, 1, 18);
      play_frame(1'b0, 1'b0, 1'b0);
      do_reset(1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      check("idle_after_sat");

      // random frames with input gaps, single-cycle holds and mode_in noise
      for (int f = 0; f < 40; f++) begin
         int m;
         m = int'($urandom_range(0, 3));
         len = (m == 1 || m == 2) ? 2 * int'($urandom_range(1, 7)) : int'($urandom_range(1, 14));
         rand_fill(m, int'($urandom_range(1, 4)), len);
         play_frame(1'b1, f % 3 == 0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
